// File: rtl/mem_loader_if.sv
// Host byte-stream and memory-write bundle between the host link and the loader.
// master = host/driver side, slave = mem_loader.
interface mem_loader_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       im_we;
    logic [7:0] im_addr;
    logic [7:0] im_wdata;
    logic       dm_we;
    logic [7:0] dm_addr;
    logic [7:0] dm_wdata;
    logic       core_start;
    logic       busy;
    logic       err;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, im_we, im_addr, im_wdata, dm_we, dm_addr, dm_wdata,
               core_start, busy, err
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, im_we, im_addr, im_wdata, dm_we, dm_addr, dm_wdata,
               core_start, busy, err
    );
endinterface

// File: rtl/mem_loader.sv
// Framed byte-stream loader: CMD/ADDR/LEN/DATA into IM/DM write strobes, CMD 0x03 pulses core_start.
// Optional trailing checksum byte per frame when LOADER_CHECKSUM_EN is defined.
module mem_loader (
    input  logic        clk,
    input  logic        rst_n,
    mem_loader_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_LEN, S_DATA, S_START
`ifdef LOADER_CHECKSUM_EN
        , S_CSUM
`endif
    } state_e;

`ifdef LOADER_CHECKSUM_EN
    localparam state_e FRAME_END = S_CSUM;
`else
    localparam state_e FRAME_END = S_IDLE;
`endif

    state_e     state_q;
    logic       tgt_dm_q;
    logic [7:0] addr_q;
    logic [7:0] rem_q;
    logic       im_we_q, dm_we_q, core_start_q, err_q;
    logic [7:0] im_addr_q, im_wdata_q, dm_addr_q, dm_wdata_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum_q;
`endif
    logic       acc;

    assign acc = bus.rx_valid && (state_q != S_START);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            tgt_dm_q     <= 1'b0;
            addr_q       <= 8'h00;
            rem_q        <= 8'h00;
            im_we_q      <= 1'b0;
            dm_we_q      <= 1'b0;
            im_addr_q    <= 8'h00;
            im_wdata_q   <= 8'h00;
            dm_addr_q    <= 8'h00;
            dm_wdata_q   <= 8'h00;
            core_start_q <= 1'b0;
            err_q        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= 8'h00;
`endif
        end else begin
            // Strobes are single-cycle unless another data byte lands this edge.
            im_we_q      <= 1'b0;
            dm_we_q      <= 1'b0;
            core_start_q <= 1'b0;
            case (state_q)
                S_IDLE: if (acc) begin
                    case (bus.rx_data)
                        8'h01: begin tgt_dm_q <= 1'b0; state_q <= S_ADDR; end
                        8'h02: begin tgt_dm_q <= 1'b1; state_q <= S_ADDR; end
                        8'h03: begin core_start_q <= 1'b1; state_q <= S_START; end
                        default: err_q <= 1'b1;
                    endcase
                end
                S_ADDR: if (acc) begin
                    addr_q  <= bus.rx_data;
                    state_q <= S_LEN;
                end
                S_LEN: if (acc) begin
                    rem_q   <= bus.rx_data;
`ifdef LOADER_CHECKSUM_EN
                    sum_q   <= 8'h00;
`endif
                    state_q <= (bus.rx_data == 8'h00) ? FRAME_END : S_DATA;
                end
                S_DATA: if (acc) begin
                    if (tgt_dm_q) begin
                        dm_we_q    <= 1'b1;
                        dm_addr_q  <= addr_q;
                        dm_wdata_q <= bus.rx_data;
                    end else begin
                        im_we_q    <= 1'b1;
                        im_addr_q  <= addr_q;
                        im_wdata_q <= bus.rx_data;
                    end
                    addr_q <= addr_q + 8'd1;
                    rem_q  <= rem_q - 8'd1;
`ifdef LOADER_CHECKSUM_EN
                    sum_q  <= sum_q + bus.rx_data;
`endif
                    if (rem_q == 8'd1) state_q <= FRAME_END;
                end
`ifdef LOADER_CHECKSUM_EN
                S_CSUM: if (acc) begin
                    if (bus.rx_data != sum_q) err_q <= 1'b1;
                    state_q <= S_IDLE;
                end
`endif
                S_START: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.rx_ready   = (state_q != S_START);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.im_we      = im_we_q;
    assign bus.im_addr    = im_addr_q;
    assign bus.im_wdata   = im_wdata_q;
    assign bus.dm_we      = dm_we_q;
    assign bus.dm_addr    = dm_addr_q;
    assign bus.dm_wdata   = dm_wdata_q;
    assign bus.core_start = core_start_q;
    assign bus.err        = err_q;
endmodule

// File: doc/mem_loader.md
# mem_loader

Host-side byte-stream loader that sits directly upstream of the quad-core processor's instruction and data memories. It parses a simple framed command stream, either IM writes, DM writes, or a start command, into single-byte memory write strobes. It then issues a one-cycle start pulse that releases the cores. It is the only writer of the memories before the cores run.

## Interface
- No parameters; address and data widths fixed at 8 bits to match the memories.
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- rx_valid  in  1  host byte valid
- rx_data  in  8  host byte
- rx_ready  out  1  loader accepts byte this cycle (transfer = rx_valid & rx_ready)
- im_we  out  1  instruction-memory write strobe
- im_addr  out  8  instruction-memory write address
- im_wdata  out  8  instruction-memory write data
- dm_we  out  1  data-memory write strobe
- dm_addr  out  8  data-memory write address
- dm_wdata  out  8  data-memory write data
- core_start  out  1  one-cycle pulse releasing cores
- busy  out  1  high while a frame is in progress (state != IDLE)
- err  out  1  sticky error flag, cleared only by reset

## Operation
- Frame format: CMD, ADDR, LEN, then LEN data bytes (plus checksum byte if configured).
- CMD values:
  - 0x01 = IM write.
  - 0x02 = DM write.
  - 0x03 = start. Single-byte frame; no ADDR or LEN.
  - Any other value sets err, the byte is discarded, and state stays IDLE.
- States: IDLE, ADDR, LEN, DATA, CSUM (only if configured), START.
- IDLE:
  - CMD 0x01/0x02 → ADDR; the target is latched.
  - CMD 0x03 → START.
- ADDR: byte latched into the address counter → LEN.
- LEN: byte latched into the remaining counter.
  - LEN = 0 → IDLE (or CSUM if configured). No writes occur.
  - Otherwise → DATA.
- DATA: each accepted byte produces one write to the latched target at the address counter.
  - Address increments mod 256; 0xFF wraps to 0x00.
  - Remaining counter decrements. When it reaches 0 → IDLE (or CSUM if configured).
- START: core_start = 1 for exactly one cycle, rx_ready = 0 → IDLE.
- rx_ready = 1 in every state except START.
- When rx_valid = 0, the loader holds its state; there is no timeout.
- im_we and dm_we are never asserted together.
- err does not block later frames.

## Timing
- Reset values:
  - rx_ready = 1 (IDLE).
  - im_we, dm_we, core_start, busy, err = 0.
  - im_addr, im_wdata, dm_addr, dm_wdata = 0x00.
- Write latency: a data byte accepted at edge N drives *_we/addr/wdata registered high during cycle N+1, for exactly one cycle.
- Strobes drop in a cycle where no data byte is accepted.
- Back-to-back data bytes produce back-to-back write cycles at consecutive addresses.
- core_start asserts the cycle after CMD 0x03 is accepted.
- An asynchronous reset mid-frame immediately returns to IDLE and clears all outputs. The partial frame is abandoned and writes already issued remain in memory.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - After the last data byte (or after LEN when LEN = 0), the state CSUM accepts one byte.
  - Expected value = 8-bit sum mod 256 of the data bytes.
  - Mismatch sets err. Data already written is not rolled back.
  - CSUM → IDLE.
- LOADER_CHECKSUM_EN undefined: there is no CSUM state, no checksum byte, and the frame ends after the last data byte.

## Test plan
- Reset then idle: all outputs at reset values and rx_ready = 1. Stream 01 10 03 AA BB CC → im_we pulses on 3 consecutive cycles with addr 0x10/0x11/0x12 and data AA/BB/CC; dm_we stays 0.
- Wrap-around: stream 02 FE 03 11 22 33 → dm writes at 0xFE, 0xFF, 0x00; busy deasserts the cycle after the last byte.
- Start and bad command:
  - Stream 03 → core_start high for exactly 1 cycle, rx_ready low in that cycle.
  - Stream 7F → err = 1 and stays 1 while a following valid frame 01 00 01 55 writes IM[0x00] = 0x55.
- Handshake gaps and reset:
  - Drop rx_valid for 5 cycles between data bytes → no strobes during the gap, address continuity preserved.
  - Assert rst_n = 0 after the 2nd of 4 data bytes → immediate IDLE; exactly 2 writes observed.
- LOADER_CHECKSUM_EN:
  - Stream 01 20 02 10 20 30 → writes done, err = 0.
  - Same frame with checksum 31 → writes done, err = 1.
  - LEN = 0 with checksum 00 → no writes, err = 0.
